// File: rtl/nios_practica_cpu_oci_access_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between the JTAG
// debug-slave command path and the Avalon debug_mem slave; one transaction in flight.
module nios_practica_cpu_oci_access_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int WR_PROTECT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              jtag_req_i,
  input  logic              jtag_write_i,
  input  logic [ADDR_W-1:0] jtag_addr_i,
  input  logic [31:0]       jtag_wdata_i,
  output logic              jtag_ack_o,
  output logic [31:0]       jtag_rdata_o,
  input  logic              av_read_i,
  input  logic              av_write_i,
  input  logic [ADDR_W-1:0] av_address_i,
  input  logic [31:0]       av_writedata_i,
  input  logic [3:0]        av_byteenable_i,
  output logic              av_waitrequest_o,
  output logic [31:0]       av_readdata_o,
  input  logic              debugack_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_be_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CntInit   = 2'(RD_LATENCY);
  localparam logic       WrProtect = (WR_PROTECT != 0);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                write_q, write_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         jtag_rdata_q, jtag_rdata_d;
  logic [31:0]         av_rdata_q, av_rdata_d;
  logic                av_req;
  logic                av_is_write;
  logic                grant_av;

  // A simultaneous read+write from Avalon is serviced as a read.
  assign av_req      = av_read_i | av_write_i;
  assign av_is_write = av_write_i & ~av_read_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b1;
      write_q      <= 1'b0;
      drop_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      jtag_rdata_q <= '0;
      av_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      drop_q       <= drop_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      cnt_q        <= cnt_d;
      jtag_rdata_q <= jtag_rdata_d;
      av_rdata_q   <= av_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    write_d      = write_q;
    drop_d       = drop_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    jtag_rdata_d = jtag_rdata_q;
    av_rdata_d   = av_rdata_q;
    grant_av     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (jtag_req_i || av_req) begin
          // On a tie the requester that did not own the last transaction wins.
          grant_av = (jtag_req_i && av_req) ? ~owner_q : av_req;
          owner_d  = grant_av;
          state_d  = ISSUE;
          if (grant_av) begin
            write_d = av_is_write;
            addr_d  = av_address_i;
            wdata_d = av_writedata_i;
            be_d    = av_byteenable_i;
            drop_d  = WrProtect & av_is_write & ~debugack_i;
          end else begin
            write_d = jtag_write_i;
            addr_d  = jtag_addr_i;
            wdata_d = jtag_wdata_i;
            be_d    = 4'hF;
            drop_d  = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CntInit;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d = DONE;
          if (owner_q) av_rdata_d = ram_rdata_i;
          else         jtag_rdata_d = ram_rdata_i;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_en_o         = (state_q == ISSUE);
  assign ram_we_o         = (state_q == ISSUE) & write_q & ~drop_q;
  assign ram_addr_o       = addr_q;
  assign ram_wdata_o      = wdata_q;
  assign ram_be_o         = be_q;
  assign jtag_ack_o       = (state_q == DONE) & ~owner_q;
  assign av_waitrequest_o = ~((state_q == DONE) & owner_q);
  assign jtag_rdata_o     = jtag_rdata_q;
  assign av_readdata_o    = av_rdata_q;
  assign owner_o          = owner_q;

endmodule

// File: tb/tb_nios_practica_cpu_oci_access_arbiter.sv
// Directed self-checking bench: one arbiter with 1-cycle RAM latency, a second with
// 3-cycle latency, each backed by a small behavioural RAM.
module tb_nios_practica_cpu_oci_access_arbiter;

  logic        clk;
  logic        reset;
  logic        jtag_req, jtag_write;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic        av_read, av_write;
  logic [7:0]  av_address;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        debugack;
  logic        jtag_req3, av_read3, av_write3;

  logic        jtag_ack, av_waitrequest, ram_en, ram_we, owner;
  logic [31:0] jtag_rdata, av_readdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;

  logic        jtag_ack3, av_waitrequest3, ram_en3, ram_we3, owner3;
  logic [31:0] jtag_rdata3, av_readdata3, ram_wdata3, ram_rdata3;
  logic [7:0]  ram_addr3;
  logic [3:0]  ram_be3;

  int passed = 0;
  int total  = 0;

  nios_practica_cpu_oci_access_arbiter #(.ADDR_W(8), .RD_LATENCY(1), .WR_PROTECT(1)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .jtag_req_i(jtag_req), .jtag_write_i(jtag_write), .jtag_addr_i(jtag_addr),
    .jtag_wdata_i(jtag_wdata), .jtag_ack_o(jtag_ack), .jtag_rdata_o(jtag_rdata),
    .av_read_i(av_read), .av_write_i(av_write), .av_address_i(av_address),
    .av_writedata_i(av_writedata), .av_byteenable_i(av_byteenable),
    .av_waitrequest_o(av_waitrequest), .av_readdata_o(av_readdata),
    .debugack_i(debugack),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_be_o(ram_be), .ram_rdata_i(ram_rdata), .owner_o(owner)
  );

  nios_practica_cpu_oci_access_arbiter #(.ADDR_W(8), .RD_LATENCY(3), .WR_PROTECT(1)) dut3 (
    .clk_i(clk), .reset_i(reset),
    .jtag_req_i(jtag_req3), .jtag_write_i(jtag_write), .jtag_addr_i(jtag_addr),
    .jtag_wdata_i(jtag_wdata), .jtag_ack_o(jtag_ack3), .jtag_rdata_o(jtag_rdata3),
    .av_read_i(av_read3), .av_write_i(av_write3), .av_address_i(av_address),
    .av_writedata_i(av_writedata), .av_byteenable_i(av_byteenable),
    .av_waitrequest_o(av_waitrequest3), .av_readdata_o(av_readdata3),
    .debugack_i(debugack),
    .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3), .ram_wdata_o(ram_wdata3),
    .ram_be_o(ram_be3), .ram_rdata_i(ram_rdata3), .owner_o(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs: byte-enabled writes, reads delayed by the instance's latency.
  logic [31:0] mem1 [256] = '{default: 32'h0};
  logic [31:0] mem3 [256] = '{default: 32'h0};
  logic [31:0] pipe3_0, pipe3_1, pipe3_2;

  always @(posedge clk) begin
    if (ram_en && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem1[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_en) ram_rdata <= mem1[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_en3 && ram_we3)
      for (int b = 0; b < 4; b++)
        if (ram_be3[b]) mem3[ram_addr3][8*b +: 8] <= ram_wdata3[8*b +: 8];
    pipe3_0 <= mem3[ram_addr3];
    pipe3_1 <= pipe3_0;
    pipe3_2 <= pipe3_1;
  end
  assign ram_rdata3 = pipe3_2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    jtag_req = 0; jtag_write = 0; jtag_addr = 0; jtag_wdata = 0;
    av_read = 0; av_write = 0; av_address = 0; av_writedata = 0; av_byteenable = 0;
    debugack = 0; jtag_req3 = 0; av_read3 = 0; av_write3 = 0;
    ram_rdata = 0;
    repeat (2) step();
    total++;
    if ({jtag_ack, av_waitrequest, ram_en, ram_we, owner} !== 5'b01001)
      $display("[TB] FAIL reset_ctrl: got %b expected 01001", {jtag_ack, av_waitrequest, ram_en, ram_we, owner});
    else passed++;
    total++;
    if ({jtag_rdata, av_readdata, ram_wdata} !== 96'h0)
      $display("[TB] FAIL reset_data: got %h expected 0", {jtag_rdata, av_readdata, ram_wdata});
    else passed++;
    total++;
    if ({ram_addr, ram_be} !== 12'h0)
      $display("[TB] FAIL reset_addr_be: got %h expected 000", {ram_addr, ram_be});
    else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_jtag_write();
    jtag_req = 1; jtag_write = 1; jtag_addr = 8'h10; jtag_wdata = 32'hDEADBEEF;
    step();
    total++;
    if ({ram_en, ram_we, owner, jtag_ack} !== 4'b1100)
      $display("[TB] FAIL jw_issue: got %b expected 1100", {ram_en, ram_we, owner, jtag_ack});
    else passed++;
    total++;
    if ({ram_addr, ram_wdata, ram_be} !== {8'h10, 32'hDEADBEEF, 4'hF})
      $display("[TB] FAIL jw_cmd: got %h expected 10deadbeeff", {ram_addr, ram_wdata, ram_be});
    else passed++;
    step();
    total++;
    if ({jtag_ack, ram_en, av_waitrequest} !== 3'b101)
      $display("[TB] FAIL jw_ack: got %b expected 101", {jtag_ack, ram_en, av_waitrequest});
    else passed++;
    jtag_req = 0;
    step();
    total++;
    if (jtag_ack !== 1'b0) $display("[TB] FAIL jw_ack_pulse: got %b expected 0", jtag_ack);
    else passed++;
  endtask

  task automatic test_av_read();
    av_read = 1; av_address = 8'h10; av_byteenable = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      step();
      total++;
      if (av_waitrequest !== (c != 3))
        $display("[TB] FAIL avr_wait_c%0d: got %b expected %b", c, av_waitrequest, (c != 3));
      else passed++;
      if (c == 1) begin
        total++;
        if ({ram_en, ram_we, owner} !== 3'b101)
          $display("[TB] FAIL avr_issue: got %b expected 101", {ram_en, ram_we, owner});
        else passed++;
      end
      if (c == 3) begin
        total++;
        if (av_readdata !== 32'hDEADBEEF)
          $display("[TB] FAIL avr_data: got %h expected deadbeef", av_readdata);
        else passed++;
        av_read = 0;
      end
    end
    total++;
    if (jtag_rdata !== 32'h0) $display("[TB] FAIL avr_jtag_rdata_held: got %h expected 0", jtag_rdata);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] rrExp [6];
    rrExp = '{4'b1001, 4'b0011, 4'b0001, 4'b1101, 4'b0100, 4'b0101};
    reset = 1'b1;
    jtag_req = 1; jtag_write = 1; jtag_addr = 8'h30; jtag_wdata = 32'h11111111;
    av_write = 1; av_address = 8'h31; av_writedata = 32'h22222222; av_byteenable = 4'hF;
    debugack = 1;
    step();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      total++;
      if ({ram_en, owner, jtag_ack, av_waitrequest} !== rrExp[(c-1)%6])
        $display("[TB] FAIL rr_c%0d {en,owner,ack,wait}: got %b expected %b",
                 c, {ram_en, owner, jtag_ack, av_waitrequest}, rrExp[(c-1)%6]);
      else passed++;
    end
    jtag_req = 0; av_write = 0;
    step();
    total++;
    if ({mem1[8'h30], mem1[8'h31]} !== {32'h11111111, 32'h22222222})
      $display("[TB] FAIL rr_mem: got %h expected 1111111122222222", {mem1[8'h30], mem1[8'h31]});
    else passed++;
  endtask

  task automatic test_write_protect();
    debugack = 0; av_write = 1; av_address = 8'h20; av_writedata = 32'hCAFEF00D; av_byteenable = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if ({ram_en, ram_we, av_waitrequest} !== {(c == 1), 1'b0, (c != 2)})
        $display("[TB] FAIL wp_drop_c%0d {en,we,wait}: got %b expected %b",
                 c, {ram_en, ram_we, av_waitrequest}, {(c == 1), 1'b0, (c != 2)});
      else passed++;
      if (c == 2) av_write = 0;
    end
    total++;
    if (mem1[8'h20] !== 32'h0) $display("[TB] FAIL wp_mem_untouched: got %h expected 0", mem1[8'h20]);
    else passed++;

    debugack = 1; av_write = 1; av_byteenable = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if ({ram_en, ram_we, av_waitrequest} !== {(c == 1), (c == 1), (c != 2)})
        $display("[TB] FAIL wp_allow_c%0d {en,we,wait}: got %b expected %b",
                 c, {ram_en, ram_we, av_waitrequest}, {(c == 1), (c == 1), (c != 2)});
      else passed++;
      if (c == 1) begin
        total++;
        if (ram_be !== 4'b0011) $display("[TB] FAIL wp_be: got %b expected 0011", ram_be);
        else passed++;
      end
      if (c == 2) av_write = 0;
    end
    total++;
    if (mem1[8'h20] !== 32'h0000F00D) $display("[TB] FAIL wp_mem_written: got %h expected 0000f00d", mem1[8'h20]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    jtag_req = 1; jtag_write = 0; jtag_addr = 8'h10;
    step();
    total++;
    if ({ram_en, ram_we, owner} !== 3'b100)
      $display("[TB] FAIL rm_issue: got %b expected 100", {ram_en, ram_we, owner});
    else passed++;
    step();
    reset = 1'b1;
    #1;
    total++;
    if ({jtag_ack, ram_en, ram_we, owner, av_waitrequest, ram_addr} !== {5'b00011, 8'h00})
      $display("[TB] FAIL rm_async: got %h expected 0300", {jtag_ack, ram_en, ram_we, owner, av_waitrequest, ram_addr});
    else passed++;
    step();
    total++;
    if (jtag_ack !== 1'b0) $display("[TB] FAIL rm_no_ack: got %b expected 0", jtag_ack);
    else passed++;
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if (jtag_ack !== (c == 3)) $display("[TB] FAIL rm_retry_ack_c%0d: got %b expected %b", c, jtag_ack, (c == 3));
      else passed++;
      if (c == 3) begin
        total++;
        if (jtag_rdata !== 32'hDEADBEEF) $display("[TB] FAIL rm_retry_data: got %h expected deadbeef", jtag_rdata);
        else passed++;
        jtag_req = 0;
      end
    end
    step();
  endtask

  task automatic test_latency3();
    jtag_req3 = 1; jtag_write = 1; jtag_addr = 8'h40; jtag_wdata = 32'h12345678;
    step();
    step();
    total++;
    if (jtag_ack3 !== 1'b1) $display("[TB] FAIL l3_write_ack: got %b expected 1", jtag_ack3);
    else passed++;
    jtag_req3 = 0;
    step();

    av_read3 = 1; av_address = 8'h40; av_byteenable = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      step();
      total++;
      if (av_waitrequest3 !== (c != 5))
        $display("[TB] FAIL l3_av_wait_c%0d: got %b expected %b", c, av_waitrequest3, (c != 5));
      else passed++;
      if (c == 5) begin
        total++;
        if (av_readdata3 !== 32'h12345678) $display("[TB] FAIL l3_av_data: got %h expected 12345678", av_readdata3);
        else passed++;
        av_read3 = 0;
      end
    end

    jtag_req3 = 1; jtag_write = 0; jtag_addr = 8'h40;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) jtag_req3 = 0;
      total++;
      if (jtag_ack3 !== (c == 5))
        $display("[TB] FAIL l3_jtag_ack_c%0d: got %b expected %b", c, jtag_ack3, (c == 5));
      else passed++;
      if (c == 5) begin
        total++;
        if (jtag_rdata3 !== 32'h12345678) $display("[TB] FAIL l3_jtag_data: got %h expected 12345678", jtag_rdata3);
        else passed++;
      end
    end
  endtask

  initial begin
    $display("[TB] starting arbiter bench");
    test_reset();
    test_jtag_write();
    test_av_read();
    test_round_robin();
    test_write_protect();
    test_reset_mid();
    test_latency3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
